// File: rtl/fifo_flagged_if.sv
// Producer/consumer bundle for fifo_flagged: request strobes and data in,
// head word, occupancy and status flags out.
interface fifo_flagged_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  rd;
    logic                  flush;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, w_data, rd, flush, clr_err,
        input  r_data, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd, flush, clr_err,
        output r_data, empty, full, almost_empty, almost_full, count,
               overflow, underflow
    );
endinterface

// File: rtl/fifo_flagged.sv
// Show-ahead synchronous FIFO with registered occupancy, threshold flags,
// sticky overflow/underflow and synchronous flush.
module fifo_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic           clk,
    input logic           reset,
    fifo_flagged_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [ADDR_WIDTH:0]   cnt, cnt_nxt;
    logic                  empty_q, full_q, ae_q, af_q, ovf_q, unf_q;
    logic                  rd_ok, wr_ok;

    // A write into a full FIFO is only legal when a read frees the slot
    // in the same cycle.
    always_comb begin
        rd_ok   = bus.rd & ~empty_q;
        wr_ok   = bus.wr & (~full_q | rd_ok);
        cnt_nxt = cnt;
        if (bus.flush)
            cnt_nxt = '0;
        else if (wr_ok & ~rd_ok)
            cnt_nxt = cnt + 1'b1;
        else if (rd_ok & ~wr_ok)
            cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok & ~bus.flush)
            mem[wptr] <= bus.w_data;
    end

    // Flags are derived from the next count so they land on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (bus.flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_ok) wptr <= wptr + 1'b1;
                if (rd_ok) rptr <= rptr + 1'b1;
            end
            cnt     <= cnt_nxt;
            empty_q <= (cnt_nxt == '0);
            full_q  <= (cnt_nxt == DEPTH_C);
            ae_q    <= (cnt_nxt <= AE_C);
            af_q    <= (cnt_nxt >= AF_C);
            ovf_q   <= (ovf_q & ~bus.clr_err) | (~bus.flush & bus.wr & ~wr_ok);
            unf_q   <= (unf_q & ~bus.clr_err) | (~bus.flush & bus.rd & ~rd_ok);
        end
    end

    assign bus.r_data       = mem[rptr];
    assign bus.count        = cnt;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged (DW=8, AW=2, AF=3, AE=1) against a
// queue-based model, plus hand-computed literal checkpoints.
module tb_fifo_flagged;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fifo_flagged_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_flagged #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, flags from occupancy rules.
    logic [DW-1:0] q[$];
    bit            m_ovf = 0, m_unf = 0;

    initial begin
        forever begin
            bit rok, wok;
            @(posedge clk or negedge reset);
            if (!reset) begin
                q.delete();
                m_ovf = 0;
                m_unf = 0;
            end else if (bus.flush) begin
                q.delete();
                if (bus.clr_err) begin
                    m_ovf = 0;
                    m_unf = 0;
                end
            end else begin
                rok = bus.rd && (q.size() > 0);
                wok = bus.wr && (q.size() < DEPTH || rok);
                if (rok) void'(q.pop_front());
                if (wok) q.push_back(bus.w_data);
                m_ovf = (m_ovf && !bus.clr_err) || (bus.wr && !wok);
                m_unf = (m_unf && !bus.clr_err) || (bus.rd && !rok);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                chk("m_count", 32'(bus.count), 32'(q.size()));
                chk("m_empty", 32'(bus.empty), 32'(q.size() == 0));
                chk("m_full", 32'(bus.full), 32'(q.size() == DEPTH));
                chk("m_aempty", 32'(bus.almost_empty), 32'(q.size() <= AE));
                chk("m_afull", 32'(bus.almost_full), 32'(q.size() >= AF));
                chk("m_ovf", 32'(bus.overflow), 32'(m_ovf));
                chk("m_unf", 32'(bus.underflow), 32'(m_unf));
                if (q.size() > 0) chk("m_rdata", 32'(bus.r_data), 32'(q[0]));
            end
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic c);
        bus.wr      = w;
        bus.w_data  = d;
        bus.rd      = r;
        bus.flush   = f;
        bus.clr_err = c;
        @(posedge clk);
        #1;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    logic [DW-1:0] fill_v  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [DW-1:0] drain_v [4] = '{8'h22, 8'h33, 8'h44, 8'h66};

    initial begin
        reset       = 1'b0;
        bus.wr      = 1'b0;
        bus.w_data  = '0;
        bus.rd      = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_aempty", 32'(bus.almost_empty), 1);
        chk("rst_afull", 32'(bus.almost_full), 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0);

        // Fill
        for (int i = 0; i < 4; i++) begin
            step(1, fill_v[i], 0, 0, 0);
            chk("fill_count", 32'(bus.count), 32'(i + 1));
            chk("fill_rdata", 32'(bus.r_data), 32'h11);
            chk("fill_aempty", 32'(bus.almost_empty), 32'(i == 0));
            chk("fill_afull", 32'(bus.almost_full), 32'(i >= 2));
            chk("fill_full", 32'(bus.full), 32'(i == 3));
        end

        // Overflow, then rd+wr at full
        step(1, 8'h55, 0, 0, 0);
        chk("ovf_flag", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 4);
        step(1, 8'h66, 1, 0, 0);
        chk("rw_full_rdata", 32'(bus.r_data), 32'h22);
        chk("rw_full_count", 32'(bus.count), 4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_rdata", 32'(bus.r_data), 32'(drain_v[i]));
            step(0, 0, 1, 0, 0);
        end
        chk("drain_empty", 32'(bus.empty), 1);

        // Underflow, rd+wr at empty, error clear
        step(0, 0, 1, 0, 0);
        chk("unf_flag", 32'(bus.underflow), 1);
        step(1, 8'h77, 1, 0, 0);
        chk("rw_empty_count", 32'(bus.count), 1);
        chk("rw_empty_rdata", 32'(bus.r_data), 32'h77);
        chk("rw_empty_unf", 32'(bus.underflow), 1);
        step(0, 0, 0, 0, 1);
        chk("clr_ovf", 32'(bus.overflow), 0);
        chk("clr_unf", 32'(bus.underflow), 0);
        step(0, 0, 1, 0, 0);
        chk("clr_drain_count", 32'(bus.count), 0);

        // Wrap-around
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(8'hA0 + i), 0, 0, 0);
            chk("wrap_count1", 32'(bus.count), 1);
            chk("wrap_rdata", 32'(bus.r_data), 32'(8'hA0 + i));
            step(0, 0, 1, 0, 0);
            chk("wrap_count0", 32'(bus.count), 0);
        end

        // Flush with a concurrent write
        for (int i = 1; i <= 3; i++) step(1, 8'(i), 0, 0, 0);
        chk("pre_flush_count", 32'(bus.count), 3);
        step(1, 8'h99, 0, 1, 0);
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_empty", 32'(bus.empty), 1);
        chk("flush_ovf", 32'(bus.overflow), 0);
        chk("flush_unf", 32'(bus.underflow), 0);
        step(1, 8'h10, 0, 0, 0);
        chk("post_flush_count", 32'(bus.count), 1);
        chk("post_flush_rdata", 32'(bus.r_data), 32'h10);
        step(0, 0, 1, 0, 0);

        // Async reset between edges with two words held, flags set
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 8'h03, 0, 0, 0);
        step(1, 8'h04, 0, 0, 0);
        chk("pre_rst_count", 32'(bus.count), 2);
        chk("pre_rst_unf", 32'(bus.underflow), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_empty", 32'(bus.empty), 1);
        chk("arst_full", 32'(bus.full), 0);
        chk("arst_aempty", 32'(bus.almost_empty), 1);
        chk("arst_afull", 32'(bus.almost_full), 0);
        chk("arst_ovf", 32'(bus.overflow), 0);
        chk("arst_unf", 32'(bus.underflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 8'hA5, 0, 0, 0);
        chk("post_rst_count", 32'(bus.count), 1);
        chk("post_rst_rdata", 32'(bus.r_data), 32'hA5);
        step(0, 0, 1, 0, 0);
        chk("post_rst_empty", 32'(bus.empty), 1);
        step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
